// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: packet-level AXI-Stream arbiter with round-robin/fixed priority and oversize watchdog
module axis_packet_arbiter #(
    parameter int PORTS        = 4,
    parameter int ROUND_ROBIN  = 1,
    parameter int LSB_PRIORITY = 1,
    parameter int MAX_BEATS    = 256,
    parameter int IDX_W        = $clog2(PORTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PORTS-1:0] s_axis_tvalid,
    input  logic [PORTS-1:0] s_axis_tlast,
    input  logic             m_axis_tready,
    output logic [PORTS-1:0] grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_encoded,
    output logic             err_oversize
);
    localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_n;
    logic [PORTS-1:0] mask, mask_n, grant_n, cand_raw, cand, pool;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IDX_W-1:0] win;
    logic             accept, last_acc, trip, rel, pick_en;

    function automatic logic [IDX_W-1:0] prio(input logic [PORTS-1:0] v);
        prio = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (LSB_PRIORITY != 0 && v[PORTS-1-i]) prio = IDX_W'(PORTS - 1 - i);
            if (LSB_PRIORITY == 0 && v[i]) prio = IDX_W'(i);
        end
    endfunction

    // Handshake decode, release detection, winner selection and next-state values
    always_comb begin
        accept   = grant_valid & |(grant & s_axis_tvalid) & m_axis_tready;
        last_acc = accept & |(grant & s_axis_tlast);
        trip     = (MAX_BEATS > 0) && accept && !last_acc && (cnt == CW'(MAX_BEATS - 1));
        rel      = last_acc | trip;
        pick_en  = ((state == IDLE) | rel) & |s_axis_tvalid;
        cand_raw = s_axis_tvalid & ~grant;
        cand     = |cand_raw ? cand_raw : s_axis_tvalid;
        pool     = (ROUND_ROBIN != 0 && |(cand & mask)) ? (cand & mask) : cand;
        win      = prio(pool);
        grant_n  = pick_en ? ({{(PORTS-1){1'b0}}, 1'b1} << win) : (rel ? '0 : grant);
        state_n  = pick_en ? BUSY : (rel ? IDLE : state);
        cnt_n    = rel ? '0 : (accept ? cnt + CW'(1) : cnt);
        mask_n   = mask;
        if (pick_en) begin
            for (int i = 0; i < PORTS; i++)
                mask_n[i] = (LSB_PRIORITY != 0) ? (i > int'(win)) : (i < int'(win));
            if ((LSB_PRIORITY != 0) ? (win == IDX_W'(PORTS - 1)) : (win == '0)) mask_n = '1;
        end
    end

    // State, grant, round-robin mask, beat counter and error pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            grant_valid  <= 1'b0;
            mask         <= '1;
            cnt          <= '0;
            err_oversize <= 1'b0;
        end else begin
            state        <= state_n;
            grant        <= grant_n;
            grant_valid  <= (state_n == BUSY);
            mask         <= mask_n;
            cnt          <= cnt_n;
            err_oversize <= trip;
        end
    end

    // Encoded index is the OR of the positions of set grant bits (grant is one-hot)
    always_comb begin
        grant_encoded = '0;
        for (int i = 0; i < PORTS; i++)
            if (grant[i]) grant_encoded = grant_encoded | IDX_W'(i);
    end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: directed scoreboard bench for three arbiter configurations
module tb_axis_packet_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] tv = '0;
    logic [3:0] tl = '0;
    logic       rdy = 1'b1;
    logic [3:0] g  [3];
    logic       gv [3];
    logic [1:0] ge [3];
    logic       er [3];

    typedef struct {
        int         inst;
        logic [3:0] g;
        logic       e;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    axis_packet_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .LSB_PRIORITY(1), .MAX_BEATS(256)) u_rr (
        .clk(clk), .rst_n(rst_n), .s_axis_tvalid(tv), .s_axis_tlast(tl), .m_axis_tready(rdy),
        .grant(g[0]), .grant_valid(gv[0]), .grant_encoded(ge[0]), .err_oversize(er[0]));

    axis_packet_arbiter #(.PORTS(4), .ROUND_ROBIN(1), .LSB_PRIORITY(1), .MAX_BEATS(4)) u_wd (
        .clk(clk), .rst_n(rst_n), .s_axis_tvalid(tv), .s_axis_tlast(tl), .m_axis_tready(rdy),
        .grant(g[1]), .grant_valid(gv[1]), .grant_encoded(ge[1]), .err_oversize(er[1]));

    axis_packet_arbiter #(.PORTS(4), .ROUND_ROBIN(0), .LSB_PRIORITY(0), .MAX_BEATS(256)) u_fp (
        .clk(clk), .rst_n(rst_n), .s_axis_tvalid(tv), .s_axis_tlast(tl), .m_axis_tready(rdy),
        .grant(g[2]), .grant_valid(gv[2]), .grant_encoded(ge[2]), .err_oversize(er[2]));

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int inst, input logic [3:0] eg, input logic ee, input string tag);
        exp_t x;
        x.inst = inst;
        x.g    = eg;
        x.e    = ee;
        x.tag  = tag;
        q.push_back(x);
    endtask

    task automatic drain();
        while (q.size() > 0) begin
            exp_t x;
            int   ei;
            x  = q.pop_front();
            ei = 0;
            for (int i = 0; i < 4; i++) if (x.g[i]) ei = i;
            cmp({x.tag, ".grant"}, 8'(g[x.inst]), 8'(x.g));
            cmp({x.tag, ".grant_valid"}, 8'(gv[x.inst]), 8'(|x.g));
            cmp({x.tag, ".grant_encoded"}, 8'(ge[x.inst]), 8'(ei));
            cmp({x.tag, ".err_oversize"}, 8'(er[x.inst]), 8'(x.e));
        end
    endtask

    task automatic drv(input logic r, input logic [3:0] v, input logic [3:0] l, input logic rd);
        rst_n = r;
        tv    = v;
        tl    = l;
        rdy   = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic st(input logic r, input logic [3:0] v, input logic [3:0] l, input logic rd,
                      input int inst, input logic [3:0] eg, input logic ee, input string tag);
        drv(r, v, l, rd);
        push(inst, eg, ee, tag);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        drv(1'b0, 4'hF, 4'hF, 1'b1);
        push(0, 4'b0000, 1'b0, "rst0");
        push(1, 4'b0000, 1'b0, "rst1");
        push(2, 4'b0000, 1'b0, "rst2");
        tick();
        st(1'b1, 4'hF, 4'hF, 1'b1, 0, 4'b0001, 1'b0, "rst_rel");
        st(1'b1, 4'hF, 4'hF, 1'b1, 0, 4'b0010, 1'b0, "rr1");
        st(1'b1, 4'hF, 4'hF, 1'b1, 0, 4'b0100, 1'b0, "rr2");
        st(1'b1, 4'hF, 4'hF, 1'b1, 0, 4'b1000, 1'b0, "rr3");
        st(1'b1, 4'hF, 4'hF, 1'b1, 0, 4'b0001, 1'b0, "rr_wrap");

        st(1'b0, 4'b0000, 4'b0000, 1'b1, 0, 4'b0000, 1'b0, "rst3");
        st(1'b1, 4'b0100, 4'b0000, 1'b1, 0, 4'b0100, 1'b0, "hold_gnt");
        st(1'b1, 4'b0101, 4'b0000, 1'b1, 0, 4'b0100, 1'b0, "hold_b1");
        st(1'b1, 4'b0001, 4'b0000, 1'b1, 0, 4'b0100, 1'b0, "hold_bub1");
        st(1'b1, 4'b0001, 4'b0000, 1'b1, 0, 4'b0100, 1'b0, "hold_bub2");
        st(1'b1, 4'b0101, 4'b0000, 1'b1, 0, 4'b0100, 1'b0, "hold_b2");
        st(1'b1, 4'b0101, 4'b0100, 1'b1, 0, 4'b0001, 1'b0, "hold_last");

        for (int i = 0; i < 5; i++)
            st(1'b1, 4'b0011, 4'b0001, 1'b0, 0, 4'b0001, 1'b0, "bp_hold");
        st(1'b1, 4'b0011, 4'b0001, 1'b1, 0, 4'b0010, 1'b0, "bp_rel");

        drv(1'b0, 4'b0010, 4'b0000, 1'b1);
        push(0, 4'b0000, 1'b0, "async_rst");
        #2;
        drain();

        st(1'b0, 4'b0000, 4'b0000, 1'b1, 1, 4'b0000, 1'b0, "rst5");
        st(1'b1, 4'b0010, 4'b0000, 1'b1, 1, 4'b0010, 1'b0, "wd_gnt");
        for (int i = 0; i < 3; i++)
            st(1'b1, 4'b0011, 4'b0000, 1'b1, 1, 4'b0010, 1'b0, "wd_beat");
        st(1'b1, 4'b0011, 4'b0000, 1'b1, 1, 4'b0001, 1'b1, "wd_trip");
        st(1'b1, 4'b0011, 4'b0001, 1'b1, 1, 4'b0010, 1'b0, "wd_after");
        for (int i = 0; i < 3; i++)
            st(1'b1, 4'b0010, 4'b0000, 1'b1, 1, 4'b0010, 1'b0, "wd_cbeat");
        st(1'b1, 4'b0010, 4'b0010, 1'b1, 1, 4'b0010, 1'b0, "wd_last_at_max");

        st(1'b0, 4'b0000, 4'b0000, 1'b1, 2, 4'b0000, 1'b0, "rst6");
        st(1'b1, 4'b0110, 4'b0000, 1'b1, 2, 4'b0100, 1'b0, "fp_first");
        st(1'b1, 4'b0110, 4'b0100, 1'b1, 2, 4'b0010, 1'b0, "fp_second");
        st(1'b1, 4'b0110, 4'b0010, 1'b1, 2, 4'b0100, 1'b0, "fp_third");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule
